// File: rtl/banked_mem_unit.sv
// Byte-banked data memory for the load/store stage. Little-endian lanes, one
// store per cycle, one load per two cycles, with a one-cycle response strobe.
module banked_mem_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_store,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault
);

    localparam int unsigned BANKS    = DATA_WIDTH / 8;
    localparam int unsigned OFFS     = $clog2(BANKS);
    localparam int unsigned MAX_SIZE = OFFS;
    localparam int unsigned IDXW     = $clog2(DEPTH_WORDS);
    localparam int unsigned WIDXW    = ADDR_WIDTH - OFFS;

    typedef enum logic {StIdle, StLoadWait} state_t;

    state_t                  state;
    logic [OFFS-1:0]         off_q;
    logic [1:0]              size_q;
    logic                    uns_q;

    logic [OFFS-1:0]         offset;
    logic [WIDXW-1:0]        word_idx;
    logic [IDXW-1:0]         bank_idx;
    logic                    accept;
    logic                    fault;
    logic                    rd_en;
    logic [BANKS-1:0]        we;
    logic [DATA_WIDTH-1:0]   wdata_sh;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   keep_mask;
    logic                    sign_bit;
    logic [DATA_WIDTH-1:0]   load_ext;
    int unsigned             span;
    int unsigned             off_i;

    assign offset   = req_addr[OFFS-1:0];
    assign word_idx = req_addr[ADDR_WIDTH-1:OFFS];
    assign bank_idx = word_idx[IDXW-1:0];
    assign accept   = req_valid && req_ready;
    // Store data is right-aligned; move byte 0 up to the addressed lane.
    assign wdata_sh = req_wdata << {offset, 3'b000};

    // Fault detection and per-lane write enables for the presented request
    always_comb begin
        span  = 32'd1 << req_size;
        off_i = 32'(offset);
        fault = (32'(req_size) > MAX_SIZE)
             || ((off_i & (span - 32'd1)) != 32'd0)
             || ((word_idx >> IDXW) != '0);
        rd_en = accept && !req_store && !fault;
        for (int k = 0; k < int'(BANKS); k++) begin
            we[k] = accept && req_store && !fault
                 && (32'(k) >= off_i) && (32'(k) < off_i + span);
        end
    end

    for (genvar k = 0; k < int'(BANKS); k++) begin : g_bank
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // One byte lane: write port with lane enable, synchronous read on load accept
        always_ff @(posedge CLOCK_50) begin
            if (we[k]) mem[bank_idx] <= wdata_sh[8*k +: 8];
            if (rd_en) rd_q <= mem[bank_idx];
        end

        assign rd_word[8*k +: 8] = rd_q;
    end

    // Lane steering and sign/zero extension of the word read at the accept edge
    always_comb begin
        shifted   = rd_word >> {off_q, 3'b000};
        keep_mask = {DATA_WIDTH{1'b1}};
        for (int s = 0; s < int'(MAX_SIZE); s++) begin
            if (size_q == 2'(s)) keep_mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << s));
        end
        // Top kept bit is the sign of the narrowed value.
        sign_bit = |(shifted & (keep_mask ^ (keep_mask >> 1)));
        load_ext = (shifted & keep_mask) | ((uns_q || !sign_bit) ? '0 : ~keep_mask);
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_store) begin
                            resp_valid <= 1'b1;
                        end else begin
                            state     <= StLoadWait;
                            req_ready <= 1'b0;
                            off_q     <= offset;
                            size_q    <= req_size;
                            uns_q     <= req_unsigned;
                        end
                    end
                end
                StLoadWait: begin
                    state      <= StIdle;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_mem_unit.sv
// Directed bench for banked_mem_unit: a monitor pops expected responses from a
// scoreboard queue filled as requests are accepted.
module tb_banked_mem_unit;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_store;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    typedef struct {
        string       tag;
        logic        fault;
        logic        hold;   // store response: rdata keeps its previous value
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_rdata = '0;

    banked_mem_unit dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_store    (req_store),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Response monitor: every strobe must match the oldest outstanding expectation
    initial begin
        exp_t        e;
        logic [31:0] want;
        forever begin
            @(negedge CLOCK_50);
            if (!resetn) begin
                prev_rdata = '0;
            end else if (resp_valid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_resp observed resp_valid=1 expected no response");
                end
                if (exp_q.size() != 0) begin
                    e    = exp_q.pop_front();
                    want = e.hold ? prev_rdata : e.rdata;
                    checks++;
                    assert (resp_fault === e.fault) else begin
                        errors++;
                        $error("FAIL %s fault observed %b expected %b", e.tag, resp_fault, e.fault);
                    end
                    checks++;
                    assert (resp_rdata === want) else begin
                        errors++;
                        $error("FAIL %s rdata observed %h expected %h", e.tag, resp_rdata, want);
                    end
                    prev_rdata = want;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Present a request, wait (bounded) for ready, accept it, return at the next negedge
    task automatic send(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic store, input logic uns,
                        input logic exp_fault, input logic [31:0] exp_rdata, input bit push);
        exp_t e;
        int   n = 0;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_store    = store;
        req_unsigned = uns;
        req_valid    = 1'b1;
        while (req_ready !== 1'b1 && n < 8) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge CLOCK_50);
        if (push) begin
            e.tag   = tag;
            e.fault = exp_fault;
            e.hold  = store && !exp_fault;
            e.rdata = exp_rdata;
            exp_q.push_back(e);
        end
        @(negedge CLOCK_50);
    endtask

    task automatic idle(input int cycles);
        req_valid = 1'b0;
        repeat (cycles) @(negedge CLOCK_50);
    endtask

    initial begin
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = '0;
        req_store    = 1'b0;
        req_unsigned = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // Word store then load with latency and ready checks
        send("st_w0", 32'd0, 32'hF0F1F2F3, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        send("ld_w0", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hF0F1F2F3, 1'b1);
        req_valid = 1'b0;
        check("ld_lat_valid_e0", 32'(resp_valid), 32'd0);
        check("ld_lat_ready_e0", 32'(req_ready), 32'd0);
        @(negedge CLOCK_50);
        check("ld_lat_valid_e1", 32'(resp_valid), 32'd1);
        check("ld_lat_ready_e1", 32'(req_ready), 32'd1);
        idle(1);

        // Lane steering and extension
        send("st_w4", 32'd4, 32'hA0A1A2A3, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        send("st_b5", 32'd5, 32'h000000AA, 2'd0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        send("ld_w4", 32'd4, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hA0A1AAA3, 1'b1);
        send("ld_b5s", 32'd5, '0, 2'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFAA, 1'b1);
        send("ld_b5u", 32'd5, '0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h000000AA, 1'b1);
        send("ld_h6s", 32'd6, '0, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFFA0A1, 1'b1);
        send("ld_h4u", 32'd4, '0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000AAA3, 1'b1);
        idle(2);

        // Faults: misaligned, oversize, out of range; memory must be untouched
        send("st_w2_mis", 32'd2, 32'hEEEEEEEE, 2'd2, 1'b1, 1'b0, 1'b1, '0, 1'b1);
        req_valid = 1'b0;
        check("fault_strobe", 32'(resp_fault), 32'd1);
        send("ld_w0_a", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hF0F1F2F3, 1'b1);
        send("st_h1_mis", 32'd1, 32'h0000EEEE, 2'd1, 1'b1, 1'b0, 1'b1, '0, 1'b1);
        send("ld_sz3", 32'd0, '0, 2'd3, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        send("st_w_oor", 32'd16384, 32'hEEEEEEEE, 2'd2, 1'b1, 1'b0, 1'b1, '0, 1'b1);
        send("ld_w_oor", 32'd16384, '0, 2'd2, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        send("ld_w0_b", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hF0F1F2F3, 1'b1);
        idle(2);

        // Reset while a load is pending drops it
        send("ld_rst", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid = 1'b0;
        #1 resetn = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_drop_valid", 32'(resp_valid), 32'd0);
            @(negedge CLOCK_50);
        end
        check("rst_drop_ready", 32'(req_ready), 32'd1);
        send("ld_w0_c", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hF0F1F2F3, 1'b1);
        idle(2);

        // Back-to-back stores with req_valid held high
        send("bb_st0", 32'd0, 32'd1, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("bb_v0", 32'(resp_valid), 32'd1);
        send("bb_st4", 32'd4, 32'd2, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("bb_v1", 32'(resp_valid), 32'd1);
        send("bb_st8", 32'd8, 32'd3, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("bb_v2", 32'(resp_valid), 32'd1);
        send("bb_ld0", 32'd0, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd1, 1'b1);
        send("bb_ld4", 32'd4, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1);
        send("bb_ld8", 32'd8, '0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd3, 1'b1);
        idle(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
